// File: rtl/mem_rq_arbiter_pkg.sv
// Shared encodings for the memory request arbiter: FSM states, owner,
// command and width codes.
package mem_rq_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam logic OWNER_FE = 1'b0;
    localparam logic OWNER_EX = 1'b1;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    localparam logic WIDTH_8  = 1'b0;
    localparam logic WIDTH_16 = 1'b1;

    // Wide enough for the largest allowed starvation limit (15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_rq_prio.sv
// Grant selection between execute and fetch, with a saturating counter
// that lets fetch win after too many consecutive execute grants.
module mem_rq_prio
    import mem_rq_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic a_rst,
    input  logic idle_i,
    input  logic ex_rq_i,
    input  logic fe_rq_i,
    output logic grant_ex_o,
    output logic grant_fe_o
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             starved;

    always_comb begin
        starved    = (starve_cnt_q == MaxCnt);
        grant_fe_o = idle_i & fe_rq_i & (~ex_rq_i | starved);
        grant_ex_o = idle_i & ex_rq_i & ~grant_fe_o;
    end

    // Only arbitration cycles touch the counter; a fetch gap resets the streak.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (idle_i) begin
            if (!fe_rq_i || grant_fe_o) begin
                starve_cnt_d = '0;
            end else if (grant_ex_o && !starved) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_rq_arbiter.sv
// Shares one memory port between execute and fetch, running one
// transaction at a time through IDLE -> ISSUE -> (WAIT) -> IDLE.
module mem_rq_arbiter
    import mem_rq_arbiter_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          a_rst,
    input  logic          ex_rq,
    input  logic          ex_cmd,
    input  logic          ex_width,
    input  logic          ex_sched,
    input  logic [AW-1:0] ex_addr,
    input  logic [DW-1:0] ex_wdata,
    input  logic          fe_rq,
    input  logic [AW-1:0] fe_addr,
    output logic          stop,
    output logic          ex_done,
    output logic [DW-1:0] ex_rdata,
    output logic          fe_done,
    output logic [DW-1:0] fe_rdata,
    output logic          mem_req,
    output logic          mem_cmd,
    output logic          mem_width,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_tag,
    input  logic          mem_ack,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_q, state_d;
    logic          mem_req_q;
    logic          grant_ex, grant_fe;
    logic          owner_q, cmd_q, width_q, sched_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          done;

    mem_rq_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk       (clk),
        .a_rst     (a_rst),
        .idle_i    (state_q == IDLE),
        .ex_rq_i   (ex_rq),
        .fe_rq_i   (fe_rq),
        .grant_ex_o(grant_ex),
        .grant_fe_o(grant_fe)
    );

    // mem_req is its own flop so the bus never sees a decode glitch.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= (state_d == ISSUE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_ex || grant_fe) state_d = ISSUE;
            ISSUE: begin
                if (mem_ack) begin
                    state_d = (cmd_q == CMD_WR || mem_rvalid) ? IDLE : WAIT;
                end
            end
            WAIT:    if (mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done = ((state_q == ISSUE) && mem_ack && (cmd_q == CMD_WR || mem_rvalid))
             || ((state_q == WAIT) && mem_rvalid);
        ex_done  = done && (owner_q == OWNER_EX);
        fe_done  = done && (owner_q == OWNER_FE);
        stop     = ex_rq & ~ex_done;
        ex_rdata = '0;
        if (ex_done && cmd_q == CMD_RD) begin
            ex_rdata = (width_q == WIDTH_16) ? mem_rdata
                                             : {{(DW-8){1'b0}}, mem_rdata[7:0]};
        end
        fe_rdata  = fe_done ? mem_rdata : '0;
        mem_req   = mem_req_q;
        mem_cmd   = cmd_q;
        mem_width = width_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_tag   = {owner_q, sched_q};
    end

    // Fetch is always a 16-bit read and carries no scheduler context.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            owner_q <= OWNER_FE;
            cmd_q   <= CMD_RD;
            width_q <= WIDTH_8;
            sched_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_fe) begin
            owner_q <= OWNER_FE;
            cmd_q   <= CMD_RD;
            width_q <= WIDTH_16;
            sched_q <= 1'b0;
            addr_q  <= fe_addr;
            wdata_q <= '0;
        end else if (grant_ex) begin
            owner_q <= OWNER_EX;
            cmd_q   <= ex_cmd;
            width_q <= ex_width;
            sched_q <= ex_sched;
            addr_q  <= ex_addr;
            wdata_q <= ex_wdata;
        end
    end

endmodule

// File: tb/tb_mem_rq_arbiter.sv
// Randomized bench for mem_rq_arbiter: the bench plays both requesters and
// the bus slave, and predicts every output from a transaction-level model.
module tb_mem_rq_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int SMAX = 3;

   logic clock = 1'b0;
   logic reset;
   logic exRq, exCmd, exWidth, exSched;
   logic [AW-1:0] exAddr, feAddr;
   logic [DW-1:0] exWdata, exRdata, feRdata, memWdata, memRdata;
   logic feRq, stop, exDone, feDone;
   logic memReq, memCmd, memWidth, memAck, memRvalid;
   logic [AW-1:0] memAddr;
   logic [1:0] memTag;

   int checks = 0;
   int errors = 0;

   // Transaction model: one live transfer, its fields, and bench-chosen bus delays.
   bit mLive, mAcked, mOwner, mCmd, mWidth, mSched;
   logic [AW-1:0] mAddr;
   logic [DW-1:0] mWdata;
   int ackCnt, rvDelay, rvCnt, starve;
   bit exDropNext, feDropNext;
   bit grantLog[$];

   always #5 clock = ~clock;

   mem_rq_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
      .clk(clock), .a_rst(reset),
      .ex_rq(exRq), .ex_cmd(exCmd), .ex_width(exWidth), .ex_sched(exSched),
      .ex_addr(exAddr), .ex_wdata(exWdata),
      .fe_rq(feRq), .fe_addr(feAddr),
      .stop(stop), .ex_done(exDone), .ex_rdata(exRdata),
      .fe_done(feDone), .fe_rdata(feRdata),
      .mem_req(memReq), .mem_cmd(memCmd), .mem_width(memWidth),
      .mem_addr(memAddr), .mem_wdata(memWdata), .mem_tag(memTag),
      .mem_ack(memAck), .mem_rvalid(memRvalid), .mem_rdata(memRdata)
   );

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives requesters (mode 0 none, 1 random, 2 always) and the bus slave.
   task automatic applyStimulus(input int mode);
      @(posedge clock);
      #1;
      if (exDropNext) exRq = 1'b0;
      if (feDropNext) feRq = 1'b0;
      exDropNext = 1'b0;
      feDropNext = 1'b0;
      if (!exRq && (mode == 2 || (mode == 1 && $urandom_range(0, 3) == 0))) begin
         exRq = 1'b1;
         exCmd = 1'($urandom);
         exWidth = 1'($urandom);
         exSched = 1'($urandom);
         exAddr = 16'($urandom);
         exWdata = 16'($urandom);
      end
      if (!feRq && (mode == 2 || (mode == 1 && $urandom_range(0, 3) == 0))) begin
         feRq = 1'b1;
         feAddr = 16'($urandom);
      end
      memAck = 1'b0;
      memRvalid = 1'b0;
      memRdata = 16'($urandom);
      if (mLive && !mAcked) begin
         if (ackCnt == 0) begin
            memAck = 1'b1;
            if (!mCmd && rvDelay == 0) memRvalid = 1'b1;
         end else begin
            ackCnt--;
            if ($urandom_range(0, 7) == 0) memRvalid = 1'b1;
         end
      end else if (mLive && mAcked) begin
         rvCnt--;
         memRvalid = (rvCnt == 0);
      end else if ($urandom_range(0, 7) == 0) begin
         memRvalid = 1'b1;
      end
   endtask

   // Compares outputs with the model on the falling edge, then advances the model.
   task automatic evaluateCycle();
      bit doneNow, expEx, expFe, wasLive, feWins;
      @(negedge clock);
      wasLive = mLive;
      doneNow = mLive && ((!mAcked && memAck && (mCmd || memRvalid)) || (mAcked && memRvalid));
      expEx = doneNow && mOwner;
      expFe = doneNow && !mOwner;
      checkOutput("mem_req", 32'(memReq), 32'(mLive && !mAcked));
      if (mLive && !mAcked) begin
         checkOutput("mem_cmd", 32'(memCmd), 32'(mCmd));
         checkOutput("mem_width", 32'(memWidth), 32'(mWidth));
         checkOutput("mem_addr", 32'(memAddr), 32'(mAddr));
         checkOutput("mem_tag_owner", 32'(memTag[1]), 32'(mOwner));
         if (mOwner) checkOutput("mem_tag_sched", 32'(memTag[0]), 32'(mSched));
         if (mOwner && mCmd) checkOutput("mem_wdata", 32'(memWdata), 32'(mWdata));
      end
      checkOutput("ex_done", 32'(exDone), 32'(expEx));
      checkOutput("fe_done", 32'(feDone), 32'(expFe));
      checkOutput("stop", 32'(stop), 32'(exRq && !expEx));
      if (expEx && !mCmd)
         checkOutput("ex_rdata", 32'(exRdata), mWidth ? 32'(memRdata) : 32'(memRdata[7:0]));
      if (expFe) checkOutput("fe_rdata", 32'(feRdata), 32'(memRdata));

      exDropNext = expEx;
      feDropNext = expFe;
      if (doneNow) begin
         mLive = 1'b0;
      end else if (mLive && !mAcked && memAck) begin
         mAcked = 1'b1;
         rvCnt = rvDelay;
      end
      if (!wasLive) begin
         if (exRq || feRq) begin
            feWins = feRq && (!exRq || starve == SMAX);
            if (feWins) begin
               mOwner = 1'b0; mCmd = 1'b0; mWidth = 1'b1; mAddr = feAddr; mSched = 1'b0;
               starve = 0;
            end else begin
               mOwner = 1'b1; mCmd = exCmd; mWidth = exWidth; mAddr = exAddr;
               mWdata = exWdata; mSched = exSched;
               starve = feRq ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
            end
            mLive = 1'b1;
            mAcked = 1'b0;
            ackCnt = $urandom_range(0, 2);
            rvDelay = mCmd ? 0 : $urandom_range(0, 3);
            grantLog.push_back(mOwner);
         end else begin
            starve = 0;
         end
      end
   endtask

   task automatic drainAll();
      for (int k = 0; k < 200 && (mLive || exRq || feRq); k++) begin
         applyStimulus(0);
         evaluateCycle();
      end
      checkOutput("drainTimeout", {29'd0, mLive, exRq, feRq}, 32'd0);
   endtask

   initial begin
      bit expOrder[8];
      expOrder = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      reset = 1'b1;
      exRq = 1'b1; exCmd = 1'b0; exWidth = 1'b0; exSched = 1'b0;
      exAddr = '0; exWdata = '0; feRq = 1'b0; feAddr = '0;
      memAck = 1'b0; memRvalid = 1'b0; memRdata = '0;
      mLive = 1'b0; mAcked = 1'b0; starve = 0;
      exDropNext = 1'b0; feDropNext = 1'b0;
      #2;
      checkOutput("rst_mem_req", 32'(memReq), 32'd0);
      checkOutput("rst_mem_addr", 32'(memAddr), 32'd0);
      checkOutput("rst_mem_tag", 32'(memTag), 32'd0);
      checkOutput("rst_mem_cmd", 32'(memCmd), 32'd0);
      checkOutput("rst_dones", {30'd0, exDone, feDone}, 32'd0);
      checkOutput("rst_rdata", {exRdata, feRdata}, 32'd0);
      checkOutput("rst_stop", 32'(stop), 32'd1);
      exRq = 1'b0;
      #10;
      reset = 1'b0;

      for (int c = 0; c < 3000; c++) begin
         applyStimulus(1);
         evaluateCycle();
      end
      drainAll();

      // Both requesters pinned high: fetch must get every (SMAX+1)th grant.
      grantLog.delete();
      for (int c = 0; c < 200 && grantLog.size() < 8; c++) begin
         applyStimulus(2);
         evaluateCycle();
      end
      checkOutput("grantCount", 32'(grantLog.size() >= 8), 32'd1);
      for (int i = 0; i < 8 && i < grantLog.size(); i++)
         checkOutput($sformatf("grantOrder%0d", i), 32'(grantLog[i]), 32'(expOrder[i]));
      drainAll();

      // Reset while waiting for read data abandons the transfer.
      @(posedge clock); #1;
      exRq = 1'b1; exCmd = 1'b0; exWidth = 1'b1; exAddr = 16'h1234;
      @(posedge clock); #1;
      memAck = 1'b1;
      @(negedge clock);
      checkOutput("wait_req", 32'(memReq), 32'd1);
      @(posedge clock); #1;
      memAck = 1'b0;
      @(negedge clock);
      checkOutput("wait_reqLow", 32'(memReq), 32'd0);
      checkOutput("wait_stop", 32'(stop), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("wait_rstReq", 32'(memReq), 32'd0);
      #2;
      reset = 1'b0;
      exRq = 1'b0;
      @(posedge clock); #1;
      memRvalid = 1'b1; memRdata = 16'hBEEF;
      @(negedge clock);
      checkOutput("wait_noDone", {30'd0, exDone, feDone}, 32'd0);

      // Reset while issuing drops mem_req without waiting for a clock edge.
      @(posedge clock); #1;
      memRvalid = 1'b0;
      feRq = 1'b1; feAddr = 16'h8000;
      @(posedge clock); #1;
      feRq = 1'b0;
      @(negedge clock);
      checkOutput("issue_req", 32'(memReq), 32'd1);
      checkOutput("issue_addr", 32'(memAddr), 32'h8000);
      checkOutput("issue_tagOwner", 32'(memTag[1]), 32'd0);
      reset = 1'b1;
      #1;
      checkOutput("issue_rstReq", 32'(memReq), 32'd0);
      #2;
      reset = 1'b0;
      @(posedge clock); #1;
      memAck = 1'b1; memRvalid = 1'b1;
      @(negedge clock);
      checkOutput("issue_noDone", {30'd0, exDone, feDone}, 32'd0);
      memAck = 1'b0; memRvalid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
